// File: rtl/crank_wheel_gen.sv
// crank_wheel_gen
//   Programmable crank-wheel transmitter. Synthesises a toothed-wheel signal
//   with a missing-tooth gap (e.g. 60-2) for closed-loop bench testing of an
//   angle-generator capture path. It is configured over an 8-bit-address /
//   16-bit-data register bus.
//
//   Optional feature: define CRANK_WHEEL_GEN_ACCEL_EN to enable the signed
//   per-tooth period step register (offset 7) for speed ramps.
//
// Register window (offset from BASE_ADDR):
//   0 CTRL  [0]=EN, [1]=POL       4 TEETH [7:0] total positions
//   1 PERL  period [15:0]         5 GAPS  [7:0] missing teeth
//   2 PERH  period [PW-1:16]      6 IDX   current tooth index (read-only)
//   3 DUTY  high clocks per tooth 7 STEP  signed period step (accel only)
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active-low
//   we         register write strobe, sampled on rising clk
//   re         register read enable
//   addr[7:0]  register address
//   data[15:0] bidirectional register data, driven only while reading the window
//   tooth_out  generated wheel signal (registered, POL applied)
//   gap_mark   one-clk pulse on the first clk of tooth index 0
//   running    generator active
module crank_wheel_gen #(
  parameter logic [7:0]  BASE_ADDR = 8'h50,
  parameter int unsigned PW        = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic        re,
  input  logic [7:0]  addr,
  inout  logic [15:0] data,
  output logic        tooth_out,
  output logic        gap_mark,
  output logic        running
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nx;

  // Bus-visible registers
  logic          ctrl_en, ctrl_pol;
  logic [PW-1:0] per_reg;
  logic [15:0]   duty_reg;
  logic [7:0]    teeth_reg, gaps_reg;
`ifdef CRANK_WHEEL_GEN_ACCEL_EN
  logic [15:0]   step_reg;
`endif

  // Set by writing EN=1; cleared when an invalid config stops the wheel,
  // so EN has to be re-written before the wheel restarts.
  logic          armed;

  // Active copies used by the current revolution
  logic [PW-1:0] per_act;
  logic [15:0]   duty_act;
  logic [7:0]    teeth_act, gaps_act;

  logic [PW-1:0] pcnt;
  logic [7:0]    tidx;

  // Address decode
  logic [8:0]  addr_off9;
  logic        in_win, wr;
  logic [2:0]  off;
  logic [15:0] rdata;

  assign addr_off9 = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign in_win    = (addr_off9 < 9'd8);
  assign off       = addr_off9[2:0];
  assign wr        = we && in_win;

  always_comb begin
    rdata = '0;
    case (off)
      3'd0: rdata = {14'd0, ctrl_pol, ctrl_en};
      3'd1: rdata = per_reg[15:0];
      3'd2: rdata = 16'(per_reg[PW-1:16]);
      3'd3: rdata = duty_reg;
      3'd4: rdata = {8'd0, teeth_reg};
      3'd5: rdata = {8'd0, gaps_reg};
      3'd6: rdata = {8'd0, tidx};
`ifdef CRANK_WHEEL_GEN_ACCEL_EN
      3'd7: rdata = step_reg;
`endif
      default: rdata = '0;
    endcase
  end

  assign data = (re && in_win) ? rdata : 'z;

  // Clamped / derived quantities
  logic [PW-1:0] per_load, per_step, duty_ext, duty_eff;
  logic [7:0]    span;
  logic          raw, last_clk, last_tooth, shadow_ok;

  assign per_load   = (per_reg < PW'(2)) ? PW'(2) : per_reg;
  assign duty_ext   = PW'(duty_act);
  assign duty_eff   = (duty_ext >= per_act) ? (per_act - PW'(1)) : duty_ext;
  assign span       = teeth_act - gaps_act;
  assign raw        = (tidx < span) && (pcnt < duty_eff);
  assign last_clk   = (pcnt == per_act - PW'(1));
  assign last_tooth = (tidx == teeth_act - 8'd1);
  assign shadow_ok  = (teeth_reg >= 8'd2) && (teeth_reg > gaps_reg);

`ifdef CRANK_WHEEL_GEN_ACCEL_EN
  // Two guard bits: one for sign, one to catch overflow past 2^PW-1.
  logic signed [PW+1:0] per_sum;
  always_comb begin
    per_sum = $signed({2'b00, per_act}) + $signed({{(PW-14){step_reg[15]}}, step_reg});
    if (per_sum < $signed((PW+2)'(2)))
      per_step = PW'(2);
    else if (per_sum[PW+1:PW] != 2'b00)
      per_step = '1;
    else
      per_step = per_sum[PW-1:0];
  end
`else
  assign per_step = per_act;
`endif

  // FSM next state and control strobes
  logic start, stop, drop, rev_wrap, tooth_wrap;

  always_comb begin
    state_nx   = state;
    start      = 1'b0;
    stop       = 1'b0;
    drop       = 1'b0;
    rev_wrap   = 1'b0;
    tooth_wrap = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_en && armed && shadow_ok) begin
          state_nx = RUN;
          start    = 1'b1;
        end
      end
      RUN: begin
        if (!ctrl_en) begin
          state_nx = IDLE;
          stop     = 1'b1;
        end else if (last_clk) begin
          if (!last_tooth) begin
            tooth_wrap = 1'b1;
          end else if (shadow_ok) begin
            rev_wrap = 1'b1;
          end else begin
            state_nx = IDLE;
            drop     = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  assign running = (state == RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_en   <= 1'b0;
      ctrl_pol  <= 1'b0;
      per_reg   <= '0;
      duty_reg  <= '0;
      teeth_reg <= '0;
      gaps_reg  <= '0;
`ifdef CRANK_WHEEL_GEN_ACCEL_EN
      step_reg  <= '0;
`endif
      armed     <= 1'b0;
      per_act   <= '0;
      duty_act  <= '0;
      teeth_act <= '0;
      gaps_act  <= '0;
      pcnt      <= '0;
      tidx      <= '0;
      gap_mark  <= 1'b0;
      tooth_out <= 1'b0;
    end else begin
      if (wr) begin
        case (off)
          3'd0: begin
            ctrl_en  <= data[0];
            ctrl_pol <= data[1];
          end
          3'd1: per_reg[15:0]    <= data;
          3'd2: per_reg[PW-1:16] <= data[PW-17:0];
          3'd3: duty_reg         <= data;
          3'd4: teeth_reg        <= data[7:0];
          3'd5: gaps_reg         <= data[7:0];
`ifdef CRANK_WHEEL_GEN_ACCEL_EN
          3'd7: step_reg         <= data;
`endif
          default: ;
        endcase
      end

      if (wr && off == 3'd0 && data[0]) armed <= 1'b1;
      else if (drop)                    armed <= 1'b0;

      gap_mark  <= start || rev_wrap;
      tooth_out <= (state == RUN && !stop && !drop) ? (raw ^ ctrl_pol) : ctrl_pol;

      // Shadow reload samples the register values from before any
      // coincident bus write, since both are non-blocking on this edge.
      if (start || rev_wrap) begin
        per_act   <= per_load;
        duty_act  <= duty_reg;
        teeth_act <= teeth_reg;
        gaps_act  <= gaps_reg;
        pcnt      <= '0;
        tidx      <= '0;
      end else if (stop || drop) begin
        pcnt <= '0;
        tidx <= '0;
      end else if (tooth_wrap) begin
        pcnt    <= '0;
        tidx    <= tidx + 8'd1;
        per_act <= per_step;
      end else if (state == RUN) begin
        pcnt <= pcnt + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_crank_wheel_gen.sv
// tb_crank_wheel_gen
//   Scoreboard bench for crank_wheel_gen. The stimulus side predicts whole
//   revolutions (pulse offsets/widths relative to gap_mark, gap intervals)
//   and register read data; a monitor compares as the DUT produces them.
module tb_crank_wheel_gen;

  localparam logic [7:0] BASE = 8'h50;
  localparam int MAXP = (1 << 24) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        we, re, drive;
  logic [7:0]  addr;
  logic [15:0] wdata;
  wire  [15:0] data;
  logic        tooth_out, gap_mark, running;

  assign data = drive ? wdata : 'z;

  crank_wheel_gen #(.BASE_ADDR(8'h50), .PW(24)) dut (
    .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .data(data),
    .tooth_out(tooth_out), .gap_mark(gap_mark), .running(running)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {int off; int wid;} pulse_t;
  pulse_t pulse_q[$];
  int     gap_q[$];
  int     rd_q[$];
  bit     pol_tb = 1'b0;

  // Reference: lay out one revolution tooth by tooth from the rules
  function automatic void push_rev(input int per, input int duty, input int teeth,
                                   input int gaps, input int step, input int interval,
                                   output int total, output int active_len);
    int p, cum, d;
    p = (per < 2) ? 2 : per;
    cum = 0;
    active_len = 0;
    gap_q.push_back(interval);
    for (int k = 0; k < teeth; k++) begin
      d = (duty >= p) ? p - 1 : duty;
      if (k < teeth - gaps && d > 0) pulse_q.push_back('{cum + 1, d});
      cum += p;
      if (k == teeth - gaps - 1) active_len = cum;
      p = p + step;
      if (p < 2) p = 2;
      if (p > MAXP) p = MAXP;
    end
    total = cum;
  endfunction

  // Monitor
  bit lvl, prev_lvl = 0, had_prev = 0;
  int pstart = 0, last_gap = 0, iv;
  pulse_t pe;

  always @(negedge clk) begin
    if (!rst) begin
      prev_lvl = 0;
      had_prev = 0;
    end else begin
      lvl = running && (tooth_out != pol_tb);
      if (lvl && !prev_lvl) pstart = cyc;
      if (!lvl && prev_lvl) begin
        if (pulse_q.size() == 0) begin
          check("unexpected_pulse", cyc - pstart, -1);
        end else begin
          pe = pulse_q.pop_front();
          check("pulse_off", pstart - last_gap, pe.off);
          check("pulse_wid", cyc - pstart, pe.wid);
        end
      end
      prev_lvl = lvl;
      if (gap_mark) begin
        iv = had_prev ? cyc - last_gap : 0;
        if (gap_q.size() == 0) check("unexpected_gap", iv, -1);
        else                   check("gap_interval", iv, gap_q.pop_front());
        had_prev = 1;
        last_gap = cyc;
      end
      if (!running) had_prev = 0;
      if (re && addr >= BASE && addr < BASE + 8'd8) begin
        if (rd_q.size() == 0) check("unexpected_read", int'(data), -1);
        else                  check("read_data", int'(data), rd_q.pop_front());
      end
    end
  end

  // Bus tasks
  task automatic wr(input int off, input int val);
    @(posedge clk); #1;
    addr = BASE + 8'(off); wdata = 16'(val); drive = 1; we = 1;
    @(posedge clk); #1;
    we = 0; drive = 0;
  endtask

  task automatic rd(input int off, input int exp);
    @(posedge clk); #1;
    addr = BASE + 8'(off); rd_q.push_back(exp); re = 1;
    @(negedge clk); #1;
    re = 0;
  endtask

  task automatic rd_idx(input int base, input int per, input int teeth);
    @(posedge clk); #1;
    addr = BASE + 8'd6; rd_q.push_back(((cyc - base) / per) % teeth); re = 1;
    @(negedge clk); #1;
    re = 0;
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  // Write lands on clock edge number w
  task automatic write_at(input int w, input int off, input int val);
    goto_cyc(w - 2);
    wr(off, val);
  endtask

  task automatic wait_gap(output int base);
    bit got = 0;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk);
      if (gap_mark) got = 1;
    end
    if (!got) check("gap_timeout", 0, 1);
    base = cyc;
  endtask

  task automatic set_cfg(input int per, input int duty, input int teeth, input int gaps);
    wr(1, per & 16'hffff);
    wr(3, duty);
    wr(4, teeth);
    wr(5, gaps);
  endtask

  task automatic check_idle(input string name);
    repeat (3) @(negedge clk);
    check({name, "_running"}, running, 0);
    check({name, "_tooth"}, tooth_out, pol_tb);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base, tot, act, tot2, act2, c_drop;
  int pa, da, ta, ga, pb, db, tb2, gb;
  bit pol_r;

  initial begin
    rst = 0; we = 0; re = 0; drive = 0; addr = 0; wdata = 0;
    repeat (3) @(posedge clk); #1;
    @(negedge clk);
    check("rst_tooth", tooth_out, 0);
    check("rst_running", running, 0);
    check("rst_gap", gap_mark, 0);
    #1 rst = 1;
    rd(0, 0);
    rd(6, 0);

    // Directed 60-2 with shadowed period change at tooth 30
    set_cfg(100, 50, 60, 2);
    wr(2, 0);
    wr(0, 1);
    push_rev(100, 50, 60, 2, 0, 0, tot, act);
    push_rev(200, 50, 60, 2, 0, tot, tot2, act2);
    wait_gap(base);
    goto_cyc(base + 5);    rd_idx(base, 100, 60);
    goto_cyc(base + 2950); rd_idx(base, 100, 60);
    write_at(base + 3010, 1, 200);
    goto_cyc(base + 5950); rd_idx(base, 100, 60);
    rd(1, 200);
    wait_gap(base);
    goto_cyc(base + 100);  rd_idx(base, 200, 60);
    write_at(base + act2, 0, 0);
    check_idle("a_stop");
    rd(6, 0);

    // Randomised revolutions, config changed mid-revolution
    for (int it = 0; it < 6; it++) begin
      pa = $urandom_range(1, 30); ta = $urandom_range(6, 16);
      ga = $urandom_range(1, ta - 1); da = $urandom_range(0, 35);
      pb = $urandom_range(1, 30); tb2 = $urandom_range(6, 16);
      gb = $urandom_range(1, tb2 - 1); db = $urandom_range(0, 35);
      pol_r = 1'($urandom_range(0, 1));
      set_cfg(pa, da, ta, ga);
`ifndef CRANK_WHEEL_GEN_ACCEL_EN
      wr(7, $urandom_range(1, 65535));
      rd(7, 0);
`endif
      pol_tb = pol_r;
      wr(0, {pol_r, 1'b1});
      push_rev(pa, da, ta, ga, 0, 0, tot, act);
      wait_gap(base);
      set_cfg(pb, db, tb2, gb);
      push_rev(pb, db, tb2, gb, 0, tot, tot2, act2);
      push_rev(pb, db, tb2, gb, 0, tot2, tot, act);
      wait_gap(base);
      rd_idx(base, (pb < 2) ? 2 : pb, tb2);
      rd(5, gb);
      wait_gap(base);
      write_at(base + act, 0, {pol_r, 1'b0});
      check_idle("b_stop");
    end

    // Clamps and invalid config at revolution start
    pol_tb = 1;
    set_cfg(1, 5, 4, 1);
    wr(0, 3);
    push_rev(1, 5, 4, 1, 0, 0, tot, act);
    wait_gap(base);
    wr(5, 4);
    c_drop = -1;
    for (int i = 0; i < 50 && c_drop < 0; i++) begin
      @(negedge clk);
      if (!running) c_drop = cyc;
    end
    check("c_drop_cycle", c_drop, base + 8);
    check("c_drop_tooth", tooth_out, 1);
    rd(6, 0);
    wr(5, 1);
    repeat (20) @(posedge clk);
    check_idle("c_not_rearmed");
    rd(0, 3);
    wr(0, 3);
    push_rev(1, 5, 4, 1, 0, 0, tot, act);
    wait_gap(base);
    write_at(base + act, 0, 2);
    check_idle("c_stop");

    // Polarity 1, disable mid-tooth
    set_cfg(20, 10, 5, 1);
    check("d_idle_level", tooth_out, 1);
    wr(0, 3);
    gap_q.push_back(0);
    pulse_q.push_back('{1, 10});
    pulse_q.push_back('{21, 6});
    wait_gap(base);
    write_at(base + 26, 0, 2);
    @(negedge clk);
    check("d_still_running", running, 1);
    @(negedge clk);
    check("d_stop_running", running, 0);
    check("d_stop_tooth", tooth_out, 1);
    rd(6, 0);
    pol_tb = 0;
    wr(0, 0);

`ifdef CRANK_WHEEL_GEN_ACCEL_EN
    // Period ramp, shadow reload restores PER each revolution
    set_cfg(1000, 500, 6, 1);
    wr(7, 16'hfff6);
    rd(7, 16'hfff6);
    wr(0, 1);
    push_rev(1000, 500, 6, 1, -10, 0, tot, act);
    push_rev(1000, 500, 6, 1, -10, tot, tot2, act2);
    wait_gap(base);
    wait_gap(base);
    write_at(base + act2, 0, 0);
    check_idle("e_ramp_stop");
    // Saturation at 2
    wr(7, 16'hf830);
    wr(0, 1);
    push_rev(1000, 500, 6, 1, -2000, 0, tot, act);
    wait_gap(base);
    write_at(base + act, 0, 0);
    check_idle("e_sat_stop");
    wr(7, 0);
`endif

    // Asynchronous reset in the middle of a run
    set_cfg(10, 4, 5, 2);
    pol_tb = 1;
    wr(0, 3);
    push_rev(10, 4, 5, 2, 0, 0, tot, act);
    wait_gap(base);
    goto_cyc(base + act + 2);
    rst = 0;
    @(negedge clk);
    check("r_tooth", tooth_out, 0);
    check("r_running", running, 0);
    check("r_gap", gap_mark, 0);
    pol_tb = 0;
    @(posedge clk); #1 rst = 1;
    for (int i = 0; i < 8; i++) rd(i, 0);
    repeat (10) @(posedge clk);
    check("r_stays_idle", running, 0);

    @(negedge clk);
    check("left_pulses", pulse_q.size(), 0);
    check("left_gaps", gap_q.size(), 0);
    check("left_reads", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
